// File: rtl/sdram_pro_arbit_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pro_arbit_pkg
// Shared definitions for the SDRAM controller arbiter:
//   - SDRAM command encodings as {cs_n, ras_n, cas_n, we_n}
//   - idle address / bank values driven while no requester owns the bus
//   - arbiter state encoding and the command/address/bank bundle type
//   - default write-starvation limit
// ---------------------------------------------------------------------------
package sdram_pro_arbit_pkg;

  // SDRAM commands, {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP             = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE          = 4'b0011;
  localparam logic [3:0] CMD_READ            = 4'b0101;
  localparam logic [3:0] CMD_WRITE           = 4'b0100;
  localparam logic [3:0] CMD_BURST_TERMINATE = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE       = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH    = 4'b0001;

  // Values parked on the address/bank pins while arbitrating
  localparam logic [11:0] ADDR_IDLE = 12'hfff;
  localparam logic [1:0]  BA_IDLE   = 2'b11;

  // Consecutive write grants tolerated while a read is waiting
  localparam int unsigned MAX_WR_CONSEC = 4;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic [1:0]  ba;
  } sdram_bus_t;

  // Bus content while nobody owns the pins
  function automatic sdram_bus_t idle_bus();
    sdram_bus_t b;
    b.cmd  = CMD_NOP;
    b.addr = ADDR_IDLE;
    b.ba   = BA_IDLE;
    return b;
  endfunction

  // A sub-module owns the bus in these states
  function automatic logic is_busy_state(arb_state_t s);
    return (s == ST_AREF) || (s == ST_WRITE) || (s == ST_READ);
  endfunction

endpackage

// File: rtl/sdram_pro_arbit_if.sv
// ---------------------------------------------------------------------------
// sdram_pro_arbit_if
// Bundles every request/grant/bus signal between the init, auto-refresh,
// write and read sub-modules, the arbiter and the SDRAM pins.
//   slave  : arbiter view (takes requests and sub-module buses, drives
//            grants and the SDRAM pins)
//   master : requester / pin side view (the opposite directions)
// ---------------------------------------------------------------------------
interface sdram_pro_arbit_if;

  // init module
  logic        init_end;
  logic [3:0]  init_cmd;
  logic [11:0] init_addr;
  logic [1:0]  init_bank;

  // auto-refresh module
  logic        aref_req;
  logic        aref_end;
  logic [3:0]  aref_cmd;
  logic [11:0] aref_addr;
  logic [1:0]  aref_bank;

  // write module
  logic        wr_req;
  logic        wr_end;
  logic [3:0]  wr_cmd;
  logic [11:0] wr_addr;
  logic [1:0]  wr_bank;
  logic [15:0] wr_sdram_data;
  logic        wr_sdram_en;

  // read module
  logic        rd_req;
  logic        rd_end;
  logic [3:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  rd_bank;

  // grants
  logic        aref_en;
  logic        wr_en;
  logic        rd_en;

  // SDRAM pins
  logic        sdram_cke;
  logic        sdram_cs_n;
  logic        sdram_ras_n;
  logic        sdram_cas_n;
  logic        sdram_we_n;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;
  logic        busy;

  modport slave (
    input  init_end, init_cmd, init_addr, init_bank,
    input  aref_req, aref_end, aref_cmd, aref_addr, aref_bank,
    input  wr_req, wr_end, wr_cmd, wr_addr, wr_bank, wr_sdram_data, wr_sdram_en,
    input  rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    output aref_en, wr_en, rd_en,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_addr, sdram_ba, sdram_dq_out, sdram_dq_oe, busy
  );

  modport master (
    output init_end, init_cmd, init_addr, init_bank,
    output aref_req, aref_end, aref_cmd, aref_addr, aref_bank,
    output wr_req, wr_end, wr_cmd, wr_addr, wr_bank, wr_sdram_data, wr_sdram_en,
    output rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    input  aref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_addr, sdram_ba, sdram_dq_out, sdram_dq_oe, busy
  );

endinterface

// File: rtl/sdram_pro_arbit.sv
// ---------------------------------------------------------------------------
// sdram_pro_arbit
// Shares the SDRAM command/address/bank/DQ bus between the init,
// auto-refresh, write and read sub-modules. One owner at a time, fixed
// priority refresh > write > read, with reads promoted above writes after
// MAX_WR_CONSEC_P back-to-back write grants while a read is pending.
//
// Ports:
//   sys_clk    : system clock
//   sys_rst_n  : asynchronous active-low reset
//   bus        : sdram_pro_arbit_if.slave -- requests, end pulses and
//                command buses from the sub-modules; grants, SDRAM pins
//                and busy out
//
// Grants and the pin mux are combinational from the state register so a
// sub-module's command reaches the pins in the same cycle it is produced.
// ---------------------------------------------------------------------------
module sdram_pro_arbit
  import sdram_pro_arbit_pkg::*;
#(
  parameter int unsigned MAX_WR_CONSEC_P = MAX_WR_CONSEC
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  sdram_pro_arbit_if.slave   bus
);

  localparam int unsigned          CNT_W   = $clog2(MAX_WR_CONSEC_P + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(MAX_WR_CONSEC_P);

  arb_state_t        r_state;
  logic [CNT_W-1:0]  r_wr_consec_cnt;
  sdram_bus_t        w_bus;
  logic              w_rd_starved;

  // Read has waited through the full allowance of write grants
  assign w_rd_starved = bus.rd_req && (r_wr_consec_cnt == CNT_MAX);

  // Ownership FSM plus the consecutive-write counter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state         <= ST_INIT;
      r_wr_consec_cnt <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (bus.init_end) begin
            r_state <= ST_ARBIT;
          end else begin
            r_state <= ST_INIT;
          end
        end
        ST_ARBIT: begin
          if (bus.aref_req) begin
            r_state <= ST_AREF;
          end else if (w_rd_starved) begin
            r_state         <= ST_READ;
            r_wr_consec_cnt <= '0;
          end else if (bus.wr_req) begin
            r_state <= ST_WRITE;
            if (r_wr_consec_cnt != CNT_MAX) begin
              r_wr_consec_cnt <= r_wr_consec_cnt + CNT_W'(1);
            end else begin
              r_wr_consec_cnt <= r_wr_consec_cnt;
            end
          end else if (bus.rd_req) begin
            r_state         <= ST_READ;
            r_wr_consec_cnt <= '0;
          end else begin
            r_state <= ST_ARBIT;
          end
        end
        ST_AREF: begin
          if (bus.aref_end) begin
            r_state <= ST_ARBIT;
          end else begin
            r_state <= ST_AREF;
          end
        end
        ST_WRITE: begin
          if (bus.wr_end) begin
            r_state <= ST_ARBIT;
          end else begin
            r_state <= ST_WRITE;
          end
        end
        ST_READ: begin
          if (bus.rd_end) begin
            r_state <= ST_ARBIT;
          end else begin
            r_state <= ST_READ;
          end
        end
        default: begin
          r_state         <= ST_INIT;
          r_wr_consec_cnt <= '0;
        end
      endcase
    end
  end

  // Route the owner's command/address/bank to the pins
  always_comb begin
    w_bus = idle_bus();
    case (r_state)
      ST_INIT:  w_bus = '{cmd: bus.init_cmd, addr: bus.init_addr, ba: bus.init_bank};
      ST_AREF:  w_bus = '{cmd: bus.aref_cmd, addr: bus.aref_addr, ba: bus.aref_bank};
      ST_WRITE: w_bus = '{cmd: bus.wr_cmd,   addr: bus.wr_addr,   ba: bus.wr_bank};
      ST_READ:  w_bus = '{cmd: bus.rd_cmd,   addr: bus.rd_addr,   ba: bus.rd_bank};
      ST_ARBIT: w_bus = idle_bus();
      default:  w_bus = idle_bus();
    endcase
  end

  // Enables drop in the end-pulse cycle; the sub-modules would otherwise
  // see enable still high and start another burst.
  assign bus.aref_en = (r_state == ST_AREF)  && !bus.aref_end;
  assign bus.wr_en   = (r_state == ST_WRITE) && !bus.wr_end;
  assign bus.rd_en   = (r_state == ST_READ)  && !bus.rd_end;

  assign bus.sdram_cke = 1'b1;
  assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = w_bus.cmd;
  assign bus.sdram_addr = w_bus.addr;
  assign bus.sdram_ba   = w_bus.ba;

  // DQ is only driven while the writer owns the bus
  assign bus.sdram_dq_out = bus.wr_sdram_data;
  assign bus.sdram_dq_oe  = (r_state == ST_WRITE) && bus.wr_sdram_en;

  assign bus.busy = is_busy_state(r_state);

endmodule

// File: tb/tb_sdram_pro_arbit.sv
// ---------------------------------------------------------------------------
// tb_sdram_pro_arbit
// Stimulus process drives the requester side at posedge+1, asks a
// behavioural model for the pin/grant values that must appear this cycle
// and queues them; a monitor pops and compares at every negedge.
// ---------------------------------------------------------------------------
module tb_sdram_pro_arbit;

  localparam int OWN_INIT = 0;
  localparam int OWN_IDLE = 1;
  localparam int OWN_REF  = 2;
  localparam int OWN_WR   = 3;
  localparam int OWN_RD   = 4;
  localparam int WR_LIMIT = 4;

  typedef struct packed {
    logic        aref_en;
    logic        wr_en;
    logic        rd_en;
    logic        cke;
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic [1:0]  ba;
    logic [15:0] dq;
    logic        dq_oe;
    logic        busy;
  } exp_t;

  logic sys_clk;
  logic sys_rst_n;
  sdram_pro_arbit_if bus();

  sdram_pro_arbit #(.MAX_WR_CONSEC_P(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  string glog   = "";

  // model: who owns the bus, how many writes since the last read, dwell
  int m_owner  = OWN_INIT;
  int m_writes = 0;
  int m_dwell  = 0;

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    exp_t a;
    logic p_a, p_w, p_r;
    p_a = 1'b0; p_w = 1'b0; p_r = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.aref_en = bus.aref_en;
        a.wr_en   = bus.wr_en;
        a.rd_en   = bus.rd_en;
        a.cke     = bus.sdram_cke;
        a.cmd     = {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};
        a.addr    = bus.sdram_addr;
        a.ba      = bus.sdram_ba;
        a.dq      = bus.sdram_dq_out;
        a.dq_oe   = bus.sdram_dq_oe;
        a.busy    = bus.busy;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL pins t=%0t got a/w/r=%b%b%b cke=%b cmd=%b addr=%h ba=%b dq=%h oe=%b busy=%b want a/w/r=%b%b%b cke=%b cmd=%b addr=%h ba=%b dq=%h oe=%b busy=%b",
                   $time, a.aref_en, a.wr_en, a.rd_en, a.cke, a.cmd, a.addr, a.ba, a.dq, a.dq_oe, a.busy,
                   e.aref_en, e.wr_en, e.rd_en, e.cke, e.cmd, e.addr, e.ba, e.dq, e.dq_oe, e.busy);
        end
      end
      if (bus.aref_en && !p_a) glog = {glog, "A"};
      if (bus.wr_en   && !p_w) glog = {glog, "W"};
      if (bus.rd_en   && !p_r) glog = {glog, "R"};
      p_a = bus.aref_en;
      p_w = bus.wr_en;
      p_r = bus.rd_en;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic rand_buses();
    bus.init_cmd  = 4'($urandom);  bus.init_addr = 12'($urandom); bus.init_bank = 2'($urandom);
    bus.aref_cmd  = 4'($urandom);  bus.aref_addr = 12'($urandom); bus.aref_bank = 2'($urandom);
    bus.wr_cmd    = 4'($urandom);  bus.wr_addr   = 12'($urandom); bus.wr_bank   = 2'($urandom);
    bus.rd_cmd    = 4'($urandom);  bus.rd_addr   = 12'($urandom); bus.rd_bank   = 2'($urandom);
    bus.wr_sdram_data = 16'($urandom);
  endtask

  // Queue what the pins must show for the current inputs, then advance
  // the model across the coming clock edge.
  task automatic cycle_step();
    exp_t e;
    int   nxt;
    if (!sys_rst_n) begin
      m_owner  = OWN_INIT;
      m_writes = 0;
    end
    e      = '0;
    e.cke  = 1'b1;
    e.dq   = bus.wr_sdram_data;
    e.cmd  = 4'b0111;
    e.addr = 12'hfff;
    e.ba   = 2'b11;
    if (m_owner == OWN_INIT) begin
      e.cmd = bus.init_cmd; e.addr = bus.init_addr; e.ba = bus.init_bank;
    end else if (m_owner == OWN_REF) begin
      e.cmd = bus.aref_cmd; e.addr = bus.aref_addr; e.ba = bus.aref_bank;
      e.aref_en = !bus.aref_end; e.busy = 1'b1;
    end else if (m_owner == OWN_WR) begin
      e.cmd = bus.wr_cmd; e.addr = bus.wr_addr; e.ba = bus.wr_bank;
      e.wr_en = !bus.wr_end; e.dq_oe = bus.wr_sdram_en; e.busy = 1'b1;
    end else if (m_owner == OWN_RD) begin
      e.cmd = bus.rd_cmd; e.addr = bus.rd_addr; e.ba = bus.rd_bank;
      e.rd_en = !bus.rd_end; e.busy = 1'b1;
    end
    exp_q.push_back(e);

    nxt = m_owner;
    if (sys_rst_n) begin
      if (m_owner == OWN_INIT && bus.init_end) nxt = OWN_IDLE;
      else if (m_owner == OWN_REF && bus.aref_end) nxt = OWN_IDLE;
      else if (m_owner == OWN_WR && bus.wr_end) nxt = OWN_IDLE;
      else if (m_owner == OWN_RD && bus.rd_end) nxt = OWN_IDLE;
      else if (m_owner == OWN_IDLE) begin
        if (bus.aref_req) nxt = OWN_REF;
        else if (bus.rd_req && m_writes >= WR_LIMIT) begin nxt = OWN_RD; m_writes = 0; end
        else if (bus.wr_req) begin nxt = OWN_WR; m_writes = (m_writes >= WR_LIMIT) ? WR_LIMIT : m_writes + 1; end
        else if (bus.rd_req) begin nxt = OWN_RD; m_writes = 0; end
      end
    end
    m_dwell = (nxt == m_owner) ? m_dwell + 1 : 0;
    m_owner = nxt;
    @(posedge sys_clk);
    #1;
  endtask

  // Sub-modules finish a job after 'hold'+1 cycles of ownership
  task automatic step_auto(input int hold);
    rand_buses();
    bus.aref_end = (m_owner == OWN_REF) && (m_dwell >= hold);
    bus.wr_end   = (m_owner == OWN_WR)  && (m_dwell >= hold);
    bus.rd_end   = (m_owner == OWN_RD)  && (m_dwell >= hold);
    cycle_step();
  endtask

  task automatic wait_owner(input int want, input string name);
    int n;
    n = 0;
    while (m_owner != want && n < 40) begin
      step_auto(2);
      n++;
    end
    if (m_owner != want) begin
      checks++; errors++;
      $display("FAIL timeout_%s owner=%0d want=%0d", name, m_owner, want);
    end
  endtask

  task automatic check_log(input string name, input string got, input string want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s order got=%s want=%s", name, got, want);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    sys_rst_n = 1'b0;
    bus.init_end = 1'b0;
    bus.aref_req = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    bus.aref_end = 1'b0; bus.wr_end = 1'b0; bus.rd_end = 1'b0;
    bus.wr_sdram_en = 1'b0;
    rand_buses();
    @(posedge sys_clk);
    #1;

    // reset, then init bus on the pins until init_end
    for (int i = 0; i < 3; i++) begin rand_buses(); cycle_step(); end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin rand_buses(); cycle_step(); end
    bus.init_end = 1'b1;
    for (int i = 0; i < 3; i++) step_auto(2);

    // all three requests together: refresh, then write, then read
    glog = "";
    bus.aref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (m_owner == OWN_REF) bus.aref_req = 1'b0;
      if (m_owner == OWN_WR)  bus.wr_req   = 1'b0;
      if (m_owner == OWN_RD)  bus.rd_req   = 1'b0;
      step_auto(2);
    end
    check_log("priority", glog, "AWR");

    // write and read held: four writes then a promoted read
    glog = "";
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    n = 0;
    while (glog.len() < 6 && n < 300) begin step_auto(2); n++; end
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    if (glog.len() >= 6) check_log("starvation", glog.substr(0, 5), "WWWWRW");
    else check_log("starvation", glog, "WWWWRW");
    wait_owner(OWN_IDLE, "drain1");

    // DQ driven in WRITE, never in READ
    bus.wr_req = 1'b1;
    wait_owner(OWN_WR, "enter_wr");
    bus.wr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_buses();
      bus.wr_sdram_en = 1'b1; bus.wr_sdram_data = 16'h1234;
      bus.wr_end = (i == 2);
      cycle_step();
    end
    bus.wr_end = 1'b0;
    bus.rd_req = 1'b1;
    wait_owner(OWN_RD, "enter_rd");
    bus.rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_buses();
      bus.wr_sdram_en = 1'b1;
      bus.rd_end = (i == 2);
      cycle_step();
    end
    bus.rd_end = 1'b0;
    bus.wr_sdram_en = 1'b0;

    // reset in the middle of a write; no grants until init_end
    bus.wr_req = 1'b1;
    wait_owner(OWN_WR, "enter_wr2");
    step_auto(9);
    sys_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step_auto(9);
    sys_rst_n = 1'b1;
    bus.init_end = 1'b0; bus.rd_req = 1'b1; bus.aref_req = 1'b1;
    for (int i = 0; i < 5; i++) step_auto(2);
    bus.init_end = 1'b1; bus.aref_req = 1'b0; bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    for (int i = 0; i < 10; i++) step_auto(2);

    // random traffic, including stray end pulses and occasional resets
    for (int i = 0; i < 3000; i++) begin
      rand_buses();
      sys_rst_n    = ($urandom_range(0, 399) != 0);
      bus.init_end = ($urandom_range(0, 9) != 0);
      bus.aref_req = ($urandom_range(0, 7) == 0);
      bus.wr_req   = ($urandom_range(0, 1) == 0);
      bus.rd_req   = ($urandom_range(0, 1) == 0);
      bus.aref_end = ($urandom_range(0, 3) == 0);
      bus.wr_end   = ($urandom_range(0, 3) == 0);
      bus.rd_end   = ($urandom_range(0, 3) == 0);
      bus.wr_sdram_en = ($urandom_range(0, 1) == 0);
      cycle_step();
    end
    sys_rst_n = 1'b1;

    @(negedge sys_clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
